// File: rtl/regfile_sequencer_if.sv
// Host-side and register-file-side signals of the regfile sequencer.
// The master modport is the sequencer; the slave is the host plus register file.
interface regfile_sequencer_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2
);
    logic                  start;
    logic                  mode;
    logic [0:DATA_W-1]     fill_data;
    logic [0:ADDR_W-1]     rw;
    logic [0:DATA_W-1]     dw;
    logic                  rg_we;
    logic [0:ADDR_W-1]     rs;
    logic [0:ADDR_W-1]     rt;
    logic [0:DATA_W-1]     crs;
    logic [0:DATA_W-1]     crt;
    logic [0:2*DATA_W-1]   out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, mode, fill_data,
        input  crs, crt, out_ready,
        output rw, dw, rg_we, rs, rt,
        output out_data, out_valid,
        output busy, done
    );

    modport slave (
        output start, mode, fill_data,
        output crs, crt, out_ready,
        input  rw, dw, rg_we, rs, rt,
        input  out_data, out_valid,
        input  busy, done
    );
endinterface

// File: rtl/regfile_sequencer.sv
// Bulk fill / dump sequencer for a small register file.
// Fill writes seed+idx to every register; dump streams register pairs.
module regfile_sequencer #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    regfile_sequencer_if.master io_bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_DUMP_RD,
        S_DUMP_OUT,
        S_DONE
    } state_t;

    localparam logic [0:ADDR_W-1] LAST_IDX  = '1;
    localparam logic [0:ADDR_W-1] LAST_PAIR =
        LAST_IDX - ADDR_W'(1);

    state_t                r_state;
    logic [0:ADDR_W-1]     r_rw;
    logic [0:DATA_W-1]     r_dw;
    logic                  r_rg_we;
    logic [0:ADDR_W-1]     r_rs;
    logic [0:ADDR_W-1]     r_rt;
    logic [0:2*DATA_W-1]   r_out_data;
    logic                  r_out_valid;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_hs;

    assign w_hs = r_out_valid & io_bus.out_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_rw        <= '0;
            r_dw        <= '0;
            r_rg_we     <= 1'b0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (io_bus.start) begin
                        r_busy <= 1'b1;
                        r_rw   <= '0;
                        r_dw   <= io_bus.fill_data;
                        r_rs   <= '0;
                        r_rt   <= ADDR_W'(1);
                        if (io_bus.mode) begin
                            r_state <= S_DUMP_RD;
                        end else begin
                            r_state <= S_FILL;
                            r_rg_we <= 1'b1;
                        end
                    end
                end
                // r_rw doubles as the fill index; r_dw wraps naturally
                S_FILL: begin
                    if (r_rw == LAST_IDX) begin
                        r_rg_we <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_rw <= r_rw + ADDR_W'(1);
                        r_dw <= r_dw + DATA_W'(1);
                    end
                end
                S_DUMP_RD: begin
                    r_out_data  <= {io_bus.crs, io_bus.crt};
                    r_out_valid <= 1'b1;
                    r_state     <= S_DUMP_OUT;
                end
                // r_rs holds 2k, so it also tells us the last pair
                S_DUMP_OUT: begin
                    if (w_hs) begin
                        r_out_valid <= 1'b0;
                        if (r_rs == LAST_PAIR) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_rs    <= r_rs + ADDR_W'(2);
                            r_rt    <= r_rt + ADDR_W'(2);
                            r_state <= S_DUMP_RD;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io_bus.rw        = r_rw;
    assign io_bus.dw        = r_dw;
    assign io_bus.rg_we     = r_rg_we;
    assign io_bus.rs        = r_rs;
    assign io_bus.rt        = r_rt;
    assign io_bus.out_data  = r_out_data;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.busy      = r_busy;
    assign io_bus.done      = r_done;
endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: register file model, vector table,
// hand sequences for reset/back-pressure, random runs vs a reference model.
module tb_regfile_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rf_clr = 1'b0;
    int checks = 0;
    int errors = 0;

    regfile_sequencer_if #(.DATA_W(4), .ADDR_W(2)) bus ();

    regfile_sequencer #(.DATA_W(4), .ADDR_W(2)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    always #5 clk = ~clk;

    logic [0:3] rf [0:3];
    logic [3:0] exp_mem [0:3];

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 4; i++) rf[i] <= 4'hA;
        end else if (bus.rg_we) begin
            rf[bus.rw] <= bus.dw;
        end
    end

    assign bus.crs = rf[bus.rs];
    assign bus.crt = rf[bus.rt];

    typedef struct {
        logic [3:0]  seed;
        logic [15:0] exp_w;
    } vec_t;

    vec_t vecs [0:3];

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    // Reference: register i gets (seed + i) mod 16.
    function automatic logic [15:0] model_fill(input logic [3:0] s);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++)
            r[15-4*i -: 4] = 4'((int'(s) + i) % 16);
        return r;
    endfunction

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_rg_we"}, bus.rg_we, 0);
        chk({tag, "_valid"}, bus.out_valid, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_rw"}, bus.rw, 0);
        chk({tag, "_dw"}, bus.dw, 0);
        chk({tag, "_rs"}, bus.rs, 0);
        chk({tag, "_rt"}, bus.rt, 0);
        chk({tag, "_data"}, bus.out_data, 0);
    endtask

    task automatic rf_clear();
        @(posedge clk); #1 rf_clr = 1'b1;
        @(posedge clk); #1 rf_clr = 1'b0;
        for (int i = 0; i < 4; i++) exp_mem[i] = 4'hA;
    endtask

    // noise keeps START high (dump mode, other seed) through DONE
    task automatic do_fill(input logic [3:0] seed,
                           input logic [15:0] exp_w,
                           input bit noise);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.mode = 1'b0;
        bus.fill_data = seed;
        @(posedge clk); #1;
        bus.start = noise;
        if (noise) begin
            bus.mode = 1'b1;
            bus.fill_data = ~seed;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("fill_we", bus.rg_we, 1);
            chk("fill_rw", bus.rw, i);
            chk("fill_dw", bus.dw, exp_w[15-4*i -: 4]);
            chk("fill_busy", bus.busy, 1);
            chk("fill_done", bus.done, 0);
        end
        @(negedge clk);
        chk("fill_we_off", bus.rg_we, 0);
        chk("fill_done_pulse", bus.done, 1);
        chk("fill_busy_off", bus.busy, 0);
        @(posedge clk); #1 bus.start = 1'b0;
        @(negedge clk);
        chk("fill_post_done", bus.done, 0);
        chk("fill_post_busy", bus.busy, 0);
        chk("fill_post_we", bus.rg_we, 0);
        for (int i = 0; i < 4; i++) begin
            exp_mem[i] = exp_w[15-4*i -: 4];
            chk("fill_rf", rf[i], exp_mem[i]);
        end
    endtask

    task automatic dump_run(input int hold, input bit rnd);
        int nb = 0;
        int low = 0;
        int last_hs = -10;
        int first_v = -1;
        bit seen = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.mode = 1'b1;
        bus.fill_data = 4'($urandom);
        bus.out_ready = rnd ? 1'($urandom % 2) : (hold == 0);
        @(posedge clk); #1 bus.start = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            chk("dump_rg_we", bus.rg_we, 0);
            if (bus.done) begin
                seen = 1'b1;
                chk("dump_done_lat", cyc, last_hs + 1);
                chk("dump_done_busy", bus.busy, 0);
                break;
            end
            chk("dump_busy", bus.busy, 1);
            if (cyc == 0) chk("dump_rd_valid", bus.out_valid, 0);
            if (bus.out_valid) begin
                if (first_v < 0) begin
                    first_v = cyc;
                    chk("dump_first_valid", cyc, 1);
                end
                if (!rnd && hold == 0)
                    chk("dump_beat_cyc", cyc, 1 + 2 * nb);
                if (nb >= 2) begin
                    chk("dump_extra_beat", bus.out_valid, 0);
                end else begin
                    chk("dump_data", bus.out_data,
                        {exp_mem[2*nb], exp_mem[2*nb+1]});
                    chk("dump_rs", bus.rs, 2 * nb);
                    chk("dump_rt", bus.rt, 2 * nb + 1);
                    if (bus.out_ready) begin
                        nb++;
                        last_hs = cyc;
                    end else begin
                        low++;
                    end
                end
            end
            @(posedge clk); #1;
            bus.out_ready = rnd ? 1'($urandom % 2) : (low >= hold);
        end
        chk("dump_done_seen", seen, 1);
        chk("dump_beats", nb, 2);
        @(negedge clk);
        chk("dump_post_done", bus.done, 0);
        chk("dump_post_valid", bus.out_valid, 0);
        bus.out_ready = 1'b1;
    endtask

    initial begin
        vecs[0] = '{4'h3, 16'h3456};
        vecs[1] = '{4'hE, 16'hEF01};
        vecs[2] = '{4'h0, 16'h0123};
        vecs[3] = '{4'h9, 16'h9ABC};

        bus.start = 1'b0;
        bus.mode = 1'b0;
        bus.fill_data = '0;
        bus.out_ready = 1'b1;
        rf_clr = 1'b1;
        repeat (2) @(posedge clk);
        #1 rf_clr = 1'b0;
        @(negedge clk);
        chk_idle_zero("reset");
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_busy", bus.busy, 0);
            chk("idle_we", bus.rg_we, 0);
        end
        for (int i = 0; i < 4; i++) exp_mem[i] = 4'hA;

        for (int v = 0; v < 4; v++) begin
            do_fill(vecs[v].seed, vecs[v].exp_w, 1'b0);
            dump_run(0, 1'b0);
        end

        do_fill(4'h3, 16'h3456, 1'b1);
        dump_run(5, 1'b0);

        rf_clear();
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.mode = 1'b0;
        bus.fill_data = 4'h3;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_pre_we", bus.rg_we, 1);
        chk("abort_pre_rw", bus.rw, 2);
        #2 rst_n = 1'b0;
        #1 chk_idle_zero("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_idle_busy", bus.busy, 0);
            chk("abort_idle_we", bus.rg_we, 0);
        end
        chk("abort_rf0", rf[0], 4'h3);
        chk("abort_rf1", rf[1], 4'h4);
        chk("abort_rf2", rf[2], 4'hA);
        chk("abort_rf3", rf[3], 4'hA);
        exp_mem[0] = 4'h3;
        exp_mem[1] = 4'h4;
        dump_run(0, 1'b0);
        do_fill(4'h0, 16'h0123, 1'b0);

        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.mode = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("beat_rst_pre_valid", bus.out_valid, 1);
        chk("beat_rst_pre_data", bus.out_data, 8'h01);
        #2 rst_n = 1'b0;
        #1 chk_idle_zero("beat_rst");
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("beat_rst_idle_valid", bus.out_valid, 0);
        end

        for (int r = 0; r < 8; r++) begin
            logic [3:0] s;
            s = 4'($urandom);
            do_fill(s, model_fill(s), 1'($urandom % 2));
            dump_run($urandom_range(0, 3), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
